// File: rtl/knn_vote_pkg.sv
// knn_vote_pkg: shared defaults, FSM state encoding and counter-width helper for the KNN vote stage
package knn_vote_pkg;
  localparam int LABEL_W_DEF   = 8;
  localparam int K_DEF         = 10;
  localparam int N_CLASSES_DEF = 4;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    SELECT = 2'd2,
    DONE   = 2'd3
  } state_e;
  function automatic int cnt_w(input int k);
    return $clog2(k + 1);
  endfunction
endpackage

// File: rtl/knn_vote_tally.sv
// knn_vote_tally: per-class vote counters and first-seen slot registers
//   clr_i        clears counters to 0 and first-seen to K_NEIGHBOURS
//   inc_i        counts one vote for inc_label_i seen at slot inc_idx_i (out-of-range labels match no class)
//   rd_class_i   selects the class shown on rd_votes_o / rd_first_o
module knn_vote_tally #(
  parameter int LABEL_W      = 8,
  parameter int K_NEIGHBOURS = 10,
  parameter int N_CLASSES    = 4,
  parameter int CNT_W        = 4,
  parameter int CLS_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               inc_i,
  input  logic [LABEL_W-1:0] inc_label_i,
  input  logic [CNT_W-1:0]   inc_idx_i,
  input  logic [CLS_W-1:0]   rd_class_i,
  output logic [CNT_W-1:0]   rd_votes_o,
  output logic [CNT_W-1:0]   rd_first_o
);
  logic [CNT_W-1:0] votes_q [N_CLASSES];
  logic [CNT_W-1:0] first_q [N_CLASSES];
  always_ff @(posedge clk)
    for (int c = 0; c < N_CLASSES; c++)
      if (!rst || clr_i) begin
        votes_q[c] <= '0;
        first_q[c] <= CNT_W'(K_NEIGHBOURS);
      end else if (inc_i && inc_label_i == LABEL_W'(c)) begin
        votes_q[c] <= votes_q[c] + CNT_W'(1);
        if (votes_q[c] == '0) first_q[c] <= inc_idx_i;
      end
  assign rd_votes_o = votes_q[rd_class_i];
  assign rd_first_o = first_q[rd_class_i];
endmodule

// File: rtl/knn_vote.sv
// knn_vote: majority vote over a sorted K-nearest label list, ties to the class whose nearest member ranks closest
//   in_valid/in_ready/in_labels/in_count   label list handshake (slot 0 nearest)
//   out_valid/out_ready                    result handshake, outputs held until accepted
//   out_label/out_votes/out_err            winning class, its vote count, no-legal-vote flag
module knn_vote import knn_vote_pkg::*; #(
  parameter int LABEL_W      = LABEL_W_DEF,
  parameter int K_NEIGHBOURS = K_DEF,
  parameter int N_CLASSES    = N_CLASSES_DEF,
  parameter int CNT_W        = cnt_w(K_NEIGHBOURS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [K_NEIGHBOURS*LABEL_W-1:0] in_labels,
  input  logic [CNT_W-1:0]                in_count,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LABEL_W-1:0]              out_label,
  output logic [CNT_W-1:0]                out_votes,
  output logic                            out_err
);
  localparam int CLS_W = N_CLASSES > 1 ? $clog2(N_CLASSES) : 1;
  localparam logic [CNT_W-1:0] K_CNT = CNT_W'(K_NEIGHBOURS);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_CLASSES - 1);
  state_e state_q, state_d;
  logic [K_NEIGHBOURS*LABEL_W-1:0] labels_q, labels_d;
  logic [CNT_W-1:0] count_q, count_d, idx_q, idx_d;
  logic [CLS_W-1:0] cls_q, cls_d;
  logic [CNT_W-1:0] best_votes_q, best_votes_d, best_first_q, best_first_d;
  logic [LABEL_W-1:0] best_label_q, best_label_d;
  logic out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [LABEL_W-1:0] out_label_q, out_label_d;
  logic [CNT_W-1:0] out_votes_q, out_votes_d;
  logic accept, tally_inc, better;
  logic [CNT_W-1:0] rd_votes, rd_first;
  assign in_ready  = state_q == IDLE;
  assign accept    = in_valid && in_ready;
  assign tally_inc = state_q == COUNT && idx_q < count_q;
  // equal vote counts only displace the current best when this class reached the list earlier
  assign better = rd_votes > best_votes_q ||
                  (rd_votes == best_votes_q && rd_votes != '0 && rd_first < best_first_q);
  knn_vote_tally #(
    .LABEL_W(LABEL_W), .K_NEIGHBOURS(K_NEIGHBOURS), .N_CLASSES(N_CLASSES),
    .CNT_W(CNT_W), .CLS_W(CLS_W)
  ) u_tally (
    .clk(clk), .rst(rst), .clr_i(accept), .inc_i(tally_inc),
    .inc_label_i(labels_q[LABEL_W-1:0]), .inc_idx_i(idx_q), .rd_class_i(cls_q),
    .rd_votes_o(rd_votes), .rd_first_o(rd_first)
  );
  always_comb begin
    state_d      = state_q;
    labels_d     = labels_q;
    count_d      = count_q;
    idx_d        = idx_q;
    cls_d        = cls_q;
    best_votes_d = best_votes_q;
    best_label_d = best_label_q;
    best_first_d = best_first_q;
    out_valid_d  = out_valid_q;
    out_label_d  = out_label_q;
    out_votes_d  = out_votes_q;
    out_err_d    = out_err_q;
    case (state_q)
      IDLE: if (accept) begin
        labels_d     = in_labels;
        count_d      = in_count > K_CNT ? K_CNT : in_count;
        idx_d        = '0;
        cls_d        = '0;
        best_votes_d = '0;
        best_label_d = '0;
        best_first_d = K_CNT;
        state_d      = COUNT;
      end
      COUNT: begin
        // the current slot always sits in the low field; shift the next one down
        labels_d = labels_q >> LABEL_W;
        idx_d    = idx_q + CNT_W'(1);
        if (count_q == '0 || idx_q + CNT_W'(1) == count_q) state_d = SELECT;
      end
      SELECT: begin
        if (better) begin
          best_votes_d = rd_votes;
          best_first_d = rd_first;
          best_label_d = LABEL_W'(cls_q);
        end
        cls_d = cls_q + CLS_W'(1);
        if (cls_q == LAST_CLS) state_d = DONE;
      end
      DONE: begin
        // first DONE cycle registers the result from the finished scan
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_label_d = best_label_q;
          out_votes_d = best_votes_q;
          out_err_d   = best_votes_q == '0;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst) begin
      state_q      <= IDLE;
      labels_q     <= '0;
      count_q      <= '0;
      idx_q        <= '0;
      cls_q        <= '0;
      best_votes_q <= '0;
      best_label_q <= '0;
      best_first_q <= K_CNT;
      out_valid_q  <= 1'b0;
      out_label_q  <= '0;
      out_votes_q  <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      labels_q     <= labels_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      cls_q        <= cls_d;
      best_votes_q <= best_votes_d;
      best_label_q <= best_label_d;
      best_first_q <= best_first_d;
      out_valid_q  <= out_valid_d;
      out_label_q  <= out_label_d;
      out_votes_q  <= out_votes_d;
      out_err_q    <= out_err_d;
    end
  assign out_valid = out_valid_q;
  assign out_label = out_label_q;
  assign out_votes = out_votes_q;
  assign out_err   = out_err_q;
endmodule

// File: tb/tb_knn_vote.sv
// tb_knn_vote: directed-vector bench for knn_vote with hand-computed results and latencies
module tb_knn_vote;
  localparam int LW = 8;
  localparam int K  = 10;
  localparam int N  = 4;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_err;
  logic [K*LW-1:0] in_labels = '0;
  logic [CW-1:0] in_count = '0;
  logic [LW-1:0] out_label;
  logic [CW-1:0] out_votes;
  int checks = 0;
  int failures = 0;
  int lab [K];
  always #5 clk = ~clk;
  knn_vote #(.LABEL_W(LW), .K_NEIGHBOURS(K), .N_CLASSES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_labels(in_labels), .in_count(in_count), .out_valid(out_valid),
    .out_ready(out_ready), .out_label(out_label), .out_votes(out_votes), .out_err(out_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start(input string tag, input int cnt);
    int w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    for (int j = 0; j < K; j++) in_labels[j*LW +: LW] = LW'(lab[j]);
    in_count = CW'(cnt);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic wait_out(input string tag, input int lat);
    int n = 0;
    check({tag, "_busy"}, 32'(in_ready), 0);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, lat);
  endtask
  task automatic expect_out(input string tag, input int label, input int votes, input int err);
    check({tag, "_label"}, 32'(out_label), label);
    check({tag, "_votes"}, 32'(out_votes), votes);
    check({tag, "_err"}, 32'(out_err), err);
  endtask
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 0);
    check({tag, "_ready_back"}, 32'(in_ready), 1);
  endtask
  task automatic run(input string tag, input int cnt, input int label, input int votes,
                     input int err, input int lat);
    start(tag, cnt);
    wait_out(tag, lat);
    expect_out(tag, label, votes, err);
    release_out(tag);
  endtask
  initial begin
    tick(2);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    expect_out("rst", 0, 0, 0);
    rst = 1'b1;
    tick();
    lab = '{2, 2, 1, 3, 2, 0, 1, 2, 3, 1};
    run("major", 10, 2, 4, 0, 15);
    lab = '{1, 3, 3, 1, 0, 0, 0, 0, 0, 0};
    run("tie_low", 5, 1, 2, 0, 10);
    lab = '{3, 1, 1, 3, 0, 0, 0, 0, 0, 0};
    run("tie_high", 5, 3, 2, 0, 10);
    run("empty", 0, 0, 0, 1, 6);
    lab = '{7, 9, 1, 0, 0, 0, 0, 0, 0, 0};
    run("range", 3, 1, 1, 0, 8);
    lab = '{5, 6, 1, 1, 1, 1, 1, 1, 1, 1};
    run("all_bad", 2, 0, 0, 1, 7);
    lab = '{1, 1, 2, 2, 2, 2, 2, 2, 2, 2};
    run("partial", 2, 1, 2, 0, 7);
    lab = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    run("sat", 15, 3, 10, 0, 15);
    lab = '{2, 2, 1, 3, 2, 0, 1, 2, 3, 1};
    start("stall", 10);
    wait_out("stall", 15);
    in_labels = '0;
    in_count = CW'(1);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      expect_out("stall", 2, 4, 0);
    end
    in_valid = 1'b0;
    release_out("stall");
    tick();
    check("stall_no_accept", 32'(in_ready), 1);
    lab = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    start("abort", 10);
    tick(3);
    rst = 1'b0;
    tick();
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    rst = 1'b1;
    tick(3);
    check("abort_quiet", 32'(out_valid), 0);
    lab = '{1, 3, 3, 1, 0, 0, 0, 0, 0, 0};
    run("after_abort", 5, 1, 2, 0, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
